// File: rtl/regfile_write_arbiter_pkg.sv
// Shared processor constants and types for the register-file writeback arbiter.
// Holds widths, the FIFO depth, the arbiter state encoding and the writeback entry record.
package regfile_write_arbiter_pkg;

    localparam int RF_AW         = 5;
    localparam int RF_DW         = 32;
    localparam int RF_NREG       = 32;
    localparam int WB_FIFO_DEPTH = 2;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } wb_entry_t;

    function automatic logic [RF_NREG-1:0] addr_onehot(input logic [RF_AW-1:0] a);
        logic [RF_NREG-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_fifo.sv
// Small shift-register FIFO holding pending writebacks for one requester.
// The pend address mask exists only when RFARB_SCOREBOARD_EN is defined.
module regfile_wb_fifo
    import regfile_write_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  wb_entry_t            in_entry,
    input  logic                 pop,
    output logic                 empty,
    output wb_entry_t            head
`ifdef RFARB_SCOREBOARD_EN
    ,
    output logic [RF_NREG-1:0]   pend
`endif
);

    localparam int CW = $clog2(WB_FIFO_DEPTH + 1);

    wb_entry_t         entries [WB_FIFO_DEPTH];
    logic [CW-1:0]     count;
    logic              push;

    // Ready comes from the registered count, so a same-cycle pop never raises it.
    assign in_ready = !rst && (count != CW'(WB_FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign empty    = (count == '0);
    assign head     = entries[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < WB_FIFO_DEPTH; i++) entries[i] <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < WB_FIFO_DEPTH - 1; i++) entries[i] <= entries[i+1];
            end
            case ({push, pop})
                2'b10: begin
                    entries[count] <= in_entry;
                    count          <= count + 1'b1;
                end
                2'b01: count <= count - 1'b1;
                2'b11: entries[count - 1'b1] <= in_entry;
                default: ;
            endcase
        end
    end

`ifdef RFARB_SCOREBOARD_EN
    always_comb begin
        pend = '0;
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            if (CW'(i) < count) pend = pend | addr_onehot(entries[i].addr);
        end
    end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging two writeback streams into one register-file write port.
// Optional busy scoreboard compiled only when RFARB_SCOREBOARD_EN is defined.
//
// state | meaning
// PRI0  | FIFO 0 wins when both FIFOs hold entries
// PRI1  | FIFO 1 wins when both FIFOs hold entries
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [RF_AW-1:0]     req0_addr,
    input  logic [RF_DW-1:0]     req0_data,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [RF_AW-1:0]     req1_addr,
    input  logic [RF_DW-1:0]     req1_data,
    output logic                 rf_rw,
    output logic [RF_AW-1:0]     rf_addr3,
    output logic [RF_DW-1:0]     rf_data3
`ifdef RFARB_SCOREBOARD_EN
    ,
    output logic [RF_NREG-1:0]   busy
`endif
);

    arb_state_e  state, state_nxt;
    logic        empty0, empty1;
    logic        gnt0, gnt1;
    wb_entry_t   head0, head1;
`ifdef RFARB_SCOREBOARD_EN
    logic [RF_NREG-1:0] pend0, pend1;
`endif

    regfile_wb_fifo u_fifo0 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (req0_valid),
        .in_ready (req0_ready),
        .in_entry ({req0_addr, req0_data}),
        .pop      (gnt0),
        .empty    (empty0),
        .head     (head0)
`ifdef RFARB_SCOREBOARD_EN
        ,
        .pend     (pend0)
`endif
    );

    regfile_wb_fifo u_fifo1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (req1_valid),
        .in_ready (req1_ready),
        .in_entry ({req1_addr, req1_data}),
        .pop      (gnt1),
        .empty    (empty1),
        .head     (head1)
`ifdef RFARB_SCOREBOARD_EN
        ,
        .pend     (pend1)
`endif
    );

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        if (!empty0 && (empty1 || state == PRI0)) gnt0 = 1'b1;
        else if (!empty1)                         gnt1 = 1'b1;
        if (gnt0)      state_nxt = PRI1;
        else if (gnt1) state_nxt = PRI0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PRI0;
        else     state <= state_nxt;
    end

    // Address/data hold their last value on idle cycles; only rf_rw drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_rw    <= 1'b0;
            rf_addr3 <= '0;
            rf_data3 <= '0;
        end else begin
            rf_rw <= gnt0 || gnt1;
            if (gnt0) begin
                rf_addr3 <= head0.addr;
                rf_data3 <= head0.data;
            end else if (gnt1) begin
                rf_addr3 <= head1.addr;
                rf_data3 <= head1.data;
            end
        end
    end

`ifdef RFARB_SCOREBOARD_EN
    assign busy = pend0 | pend1 | (rf_rw ? addr_onehot(rf_addr3) : '0);
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table, corner sequences, random run.
// Busy checks are active only when RFARB_SCOREBOARD_EN is defined.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        rf_rw;
    logic [4:0]  rf_addr3;
    logic [31:0] rf_data3;
`ifdef RFARB_SCOREBOARD_EN
    logic [31:0] busy;
`endif

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_rw      (rf_rw),
        .rf_addr3   (rf_addr3),
        .rf_data3   (rf_data3)
`ifdef RFARB_SCOREBOARD_EN
        ,
        .busy       (busy)
`endif
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        exp_rw;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    // Reference model: two queues, a "favoured requester" integer, and the last write.
    ent_t        q0[$], q1[$];
    int          fav;
    logic        m_rw;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        fav    = 0;
        m_rw   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = '0;
        foreach (q0[i]) m[q0[i].addr] = 1'b1;
        foreach (q1[i]) m[q1[i].addr] = 1'b1;
        if (m_rw) m[m_addr] = 1'b1;
        return m;
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_rw"},   rf_rw,    m_rw);
        chk({tag, "_addr"}, rf_addr3, m_addr);
        chk({tag, "_data"}, rf_data3, m_data);
`ifdef RFARB_SCOREBOARD_EN
        chk({tag, "_busy"}, busy, model_busy());
`endif
    endtask

    // Called just after a falling edge; returns after the next falling edge.
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        output bit acc0, output bit acc1);
        int   g;
        ent_t e;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        chk("ready0", req0_ready, (q0.size() < 2));
        chk("ready1", req1_ready, (q1.size() < 2));
        acc0 = v0 && (q0.size() < 2);
        acc1 = v1 && (q1.size() < 2);
        @(posedge clk);
        g = -1;
        if (q0.size() > 0 && q1.size() > 0) g = fav;
        else if (q0.size() > 0)             g = 0;
        else if (q1.size() > 0)             g = 1;
        if (g == 0) e = q0.pop_front();
        else if (g == 1) e = q1.pop_front();
        if (g >= 0) begin
            m_rw   = 1'b1;
            m_addr = e.addr;
            m_data = e.data;
            fav    = 1 - g;
        end else begin
            m_rw = 1'b0;
        end
        if (acc0) q0.push_back({a0, d0});
        if (acc1) q1.push_back({a1, d1});
        @(negedge clk);
        check_outputs("step");
        cyc++;
    endtask

    task automatic idle(input int n);
        bit a0, a1;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a0, a1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_rw", rf_rw, 1'b0);
        chk("rst_addr", rf_addr3, 5'd0);
        chk("rst_data", rf_data3, 32'd0);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
`ifdef RFARB_SCOREBOARD_EN
        chk("rst_busy", busy, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Asserts reset between clock edges and checks the asynchronous clear.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("mrst_rw", rf_rw, 1'b0);
        chk("mrst_ready0", req0_ready, 1'b0);
        chk("mrst_ready1", req1_ready, 1'b0);
`ifdef RFARB_SCOREBOARD_EN
        chk("mrst_busy", busy, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t        tbl[11];
    logic [4:0]  wlog_addr[$];
    logic [31:0] wlog_data[$];
    int          wlog_cyc[$];

    initial begin
        bit   acc0, acc1;
        int   s0, s1, rw_seen;
        bit   saw_low;
        logic [4:0] exp_ord[8];

        tbl[0]  = '{1'b1, 5'd5,  32'h0000_DEAD, 1'b0, 5'd0,  32'h0, 1'b0, 5'd0,  32'h0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0, 1'b1, 5'd5,  32'h0000_DEAD};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0, 1'b0, 5'd5,  32'h0000_DEAD};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd20, 32'h55, 1'b0, 5'd5, 32'h0000_DEAD};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0, 1'b1, 5'd20, 32'h55};
        tbl[5]  = '{1'b1, 5'd3,  32'h1,         1'b1, 5'd3,  32'h2, 1'b0, 5'd20, 32'h55};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0, 1'b1, 5'd3,  32'h1};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0, 1'b1, 5'd3,  32'h2};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0, 1'b0, 5'd3,  32'h2};
        tbl[9]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0, 1'b0, 5'd3,  32'h2};
        tbl[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0, 1'b1, 5'd0,  32'hFFFF_FFFF};

        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Single write, same-address race, address 0.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, acc0, acc1);
            chk($sformatf("tbl%0d_rw", i),   rf_rw,    tbl[i].exp_rw);
            chk($sformatf("tbl%0d_addr", i), rf_addr3, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_data", i), rf_data3, tbl[i].exp_data);
        end

        // Contention from reset: strict alternation with no idle cycle.
        do_reset();
        exp_ord = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
        s0 = 0; s1 = 0;
        wlog_addr.delete(); wlog_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            step(s0 < 4, 5'(1 + s0), 32'hA0 + s0, s1 < 4, 5'(9 + s1), 32'hB0 + s1, acc0, acc1);
            if (acc0) s0++;
            if (acc1) s1++;
            if (rf_rw === 1'b1) begin
                wlog_addr.push_back(rf_addr3);
                wlog_cyc.push_back(i);
            end
        end
        chk("cont_count", wlog_addr.size(), 8);
        if (wlog_addr.size() == 8) begin
            for (int i = 0; i < 8; i++) chk($sformatf("cont_ord%0d", i), wlog_addr[i], exp_ord[i]);
            chk("cont_no_gap", wlog_cyc[7] - wlog_cyc[0], 7);
        end

        // Backpressure on requester 1 while requester 0 streams.
        do_reset();
        s0 = 0; s1 = 0; saw_low = 1'b0;
        wlog_data.delete();
        for (int i = 0; i < 20; i++) begin
            step(s0 < 4, 5'(16 + s0), 32'hC000 + s0, s1 < 3, 5'(24 + s1), 32'hB000 + s1, acc0, acc1);
            if (acc0) s0++;
            if (acc1) s1++;
            if (req1_ready === 1'b0 && q1.size() == 2) saw_low = 1'b1;
            if (rf_rw === 1'b1 && rf_data3[31:12] == 20'hB) wlog_data.push_back(rf_data3);
        end
        chk("bp_ready1_low", saw_low, 1'b1);
        chk("bp_req1_count", wlog_data.size(), 3);
        if (wlog_data.size() == 3)
            for (int i = 0; i < 3; i++) chk($sformatf("bp_req1_%0d", i), wlog_data[i], 32'hB000 + i);

        // Reset with writes still pending in both FIFOs.
        do_reset();
        step(1'b1, 5'd21, 32'h21, 1'b1, 5'd22, 32'h22, acc0, acc1);
        step(1'b1, 5'd23, 32'h23, 1'b1, 5'd24, 32'h24, acc0, acc1);
        chk("mr_pending", q0.size() + q1.size(), 3);
        mid_reset();
        rw_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc0, acc1);
            if (rf_rw !== 1'b0) rw_seen++;
        end
        chk("mr_no_stale", rw_seen, 0);
        step(1'b1, 5'd25, 32'h25, 1'b0, 5'd0, 32'd0, acc0, acc1);
        chk("mr_accept", acc0, 1'b1);
        idle(1);
        chk("mr_after_addr", rf_addr3, 5'd25);

`ifdef RFARB_SCOREBOARD_EN
        do_reset();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, acc0, acc1);
        chk("sb_busy7_acc", busy[7], 1'b1);
        idle(1);
        chk("sb_busy7_wr", busy[7], 1'b1);
        idle(1);
        chk("sb_busy7_done", busy[7], 1'b0);
`endif

        // Random traffic, with occasional asynchronous reset.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom, acc0, acc1);
            if ($urandom_range(0, 149) == 0) mid_reset();
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
